exe_stage: RTL
==============

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- freeze  in  1  hold status register and output register
- mem_read_in, mem_write_in, wb_en_in, imm_in, b_in, s_in  in  1 each  control fields from ID/EXE register
- exe_cmd_in  in  4  ALU command
- dst_in  in  4  destination register number
- pc_in, val_rn_in, val_rm_in  in  32 each  PC+4, Rn value, Rm value
- shifter_operand_in  in  12  shifter operand field
- signed_imm_in  in  24  branch offset
- sel_src1, sel_src2  in  2 each  forwarding selects
- mem_fwd_value, wb_fwd_value  in  32 each  forwarded values from MEM and WB
- branch_taken  out  1  equals b_in; drives IF PC mux and pipeline flush
- branch_addr  out  32  branch target
- status_out  out  4  NZCV register, N in bit 3
- alu_result_out, store_val_out  out  32 each  registered EXE/MEM data
- dst_out  out  4  registered destination
- mem_read_out, mem_write_out, wb_en_out  out  1 each  registered controls

Function
REQ-002 Operand A SHALL be val_rn_in, or the forwarded value when FORWARDING_EN applies.
REQ-003 Operand Rm SHALL be val_rm_in, or the forwarded value when FORWARDING_EN applies.
REQ-004 Val2 SHALL be selected in this priority order:
- imm_in=1: zero-extended shifter_operand_in[7:0] rotated right by 2*shifter_operand_in[11:8].
- Else, mem_read_in or mem_write_in: zero-extended shifter_operand_in[11:0].
- Else: Rm shifted by shifter_operand_in[11:7]; type [6:5] = 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Rm unchanged.
REQ-005 ALU operations by exe_cmd_in:
- 0001 MOV = Val2
- 1001 MVN = ~Val2
- 0010 ADD = A+Val2
- 0011 ADC = A+Val2+C
- 0100 SUB = A-Val2
- 0101 SBC = A-Val2-(~C)
- 0110 AND
- 0111 ORR
- 1000 EOR
- Any other code: result 0, flags N/Z from the result, C=V=0.
REQ-006 Flag rules:
- N = result[31]; Z = (result==0).
- ADD/ADC: C is the 33rd bit of the sum.
- SUB/SBC: C = NOT borrow.
- V = signed overflow for arithmetic operations.
- Logical and move operations: C=0, V=0.
REQ-007 branch_addr SHALL equal pc_in + (sign-extended signed_imm_in << 2), computed combinationally, with wrap-around modulo 2^32.
REQ-008 branch_taken SHALL equal b_in combinationally, independent of freeze.
REQ-009 On a rising edge with s_in=1 and freeze=0, status_out SHALL load the REQ-006 flags; otherwise it holds its value.
REQ-010 On a rising edge with freeze=0, the EXE/MEM outputs SHALL load: ALU result, the post-forwarding Rm value as store_val_out, dst_in, mem_read_in, mem_write_in, wb_en_in. Latency is 1 cycle.
REQ-011 With freeze=1, every registered output SHALL hold its value.
REQ-012 ADC/SBC SHALL use the status_out value present before the edge; a same-cycle s_in update SHALL NOT feed back into the current result.

Reset
REQ-013 While rst=0, status_out, alu_result_out, store_val_out and dst_out SHALL be 0, and mem_read_out, mem_write_out and wb_en_out SHALL be 0, immediately and asynchronously.
REQ-014 A reset asserted mid-operation SHALL discard the in-flight result, and reset SHALL override freeze.
REQ-015 The first capture after rst returns high SHALL occur on the next rising edge.

Configuration
REQ-016 Macro FORWARDING_EN: when defined, sel=00 selects the register value, 01 selects mem_fwd_value, 10 selects wb_fwd_value, and 11 selects the register value; the selects apply independently to A (sel_src1) and Rm (sel_src2).
REQ-017 Without FORWARDING_EN, the sel and forwarding ports SHALL remain on the interface but be ignored, and the register values SHALL always be used.

Verification
REQ-018 ADD, A=0x7FFFFFFF, Val2=1, s_in=1 -> next edge: alu_result_out=0x80000000, status_out=1001 (N,V).
REQ-019 SUB 5-5, s_in=1 -> alu_result_out=0, status_out=0110 (Z,C); following ADC 1+1 -> result 3.
REQ-020 imm_in=1, shifter_operand=0x2FF -> Val2=0xF000000F; MOV -> alu_result_out=0xF000000F.
REQ-021 b_in=1, pc_in=0x100, signed_imm=0xFFFFFF -> branch_taken=1, branch_addr=0xFC in the same cycle.
REQ-022 freeze=1 for 3 cycles with changing inputs -> all outputs constant; then rst=0 mid-freeze -> all outputs 0 without waiting for a clock edge.
REQ-023 With FORWARDING_EN: sel_src1=01, mem_fwd_value=10, val_rn_in=99, ADD Val2=1 -> result 11. Without the macro -> result 100.

Source files
------------

// File: rtl/exe_stage.sv
// EXE pipeline stage: forwarding, Val2 generation, ALU with NZCV, branch target, EXE/MEM register.
// One-cycle latency; freeze holds all registers. Optional forwarding muxes under `FORWARDING_EN.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        wb_en_in,
  input  logic        imm_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [3:0]  dst_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [11:0] shifter_operand_in,
  input  logic [23:0] signed_imm_in,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] mem_fwd_value,
  input  logic [31:0] wb_fwd_value,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  status_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_val_out,
  output logic [3:0]  dst_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        wb_en_out
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [31:0] w_op_a;
  logic [31:0] w_op_rm;
  logic [31:0] w_imm32;
  logic [4:0]  w_rot;
  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_val2;
  logic [32:0] w_sum;
  logic [31:0] w_alu_res;
  logic        w_c;
  logic        w_v;
  logic [3:0]  w_flags;

  logic [3:0]  r_status;
  logic [31:0] r_alu_result;
  logic [31:0] r_store_val;
  logic [3:0]  r_dst;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_wb_en;

`ifdef FORWARDING_EN
  always_comb begin
    case (sel_src1)
      2'b01:   w_op_a = mem_fwd_value;
      2'b10:   w_op_a = wb_fwd_value;
      default: w_op_a = val_rn_in;
    endcase
    case (sel_src2)
      2'b01:   w_op_rm = mem_fwd_value;
      2'b10:   w_op_rm = wb_fwd_value;
      default: w_op_rm = val_rm_in;
    endcase
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{sel_src1, sel_src2, mem_fwd_value, wb_fwd_value};
  assign w_op_a  = val_rn_in;
  assign w_op_rm = val_rm_in;
`endif

  // A zero rotate/shift amount makes the (32 - n) left shift a full-width shift, which yields 0.
  assign w_imm32 = {24'b0, shifter_operand_in[7:0]};
  assign w_rot   = {shifter_operand_in[11:8], 1'b0};
  assign w_shamt = shifter_operand_in[11:7];

  always_comb begin
    case (shifter_operand_in[6:5])
      2'b00:   w_shifted = w_op_rm << w_shamt;
      2'b01:   w_shifted = w_op_rm >> w_shamt;
      2'b10:   w_shifted = $signed(w_op_rm) >>> w_shamt;
      default: w_shifted = (w_op_rm >> w_shamt) | (w_op_rm << (6'd32 - {1'b0, w_shamt}));
    endcase
  end

  always_comb begin
    if (imm_in)
      w_val2 = (w_imm32 >> w_rot) | (w_imm32 << (6'd32 - {1'b0, w_rot}));
    else if (mem_read_in || mem_write_in)
      w_val2 = {20'b0, shifter_operand_in};
    else
      w_val2 = w_shifted;
  end

  // Subtraction is A + ~Val2 + carry-in, so the carry-out is directly NOT borrow.
  always_comb begin
    w_sum     = '0;
    w_alu_res = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    case (exe_cmd_in)
      CMD_MOV: w_alu_res = w_val2;
      CMD_MVN: w_alu_res = ~w_val2;
      CMD_ADD, CMD_ADC: begin
        w_sum     = {1'b0, w_op_a} + {1'b0, w_val2}
                  + {32'b0, (exe_cmd_in == CMD_ADC) & r_status[1]};
        w_alu_res = w_sum[31:0];
        w_c       = w_sum[32];
        w_v       = (w_op_a[31] == w_val2[31]) && (w_sum[31] != w_op_a[31]);
      end
      CMD_SUB, CMD_SBC: begin
        w_sum     = {1'b0, w_op_a} + {1'b0, ~w_val2}
                  + {32'b0, (exe_cmd_in == CMD_SUB) | r_status[1]};
        w_alu_res = w_sum[31:0];
        w_c       = w_sum[32];
        w_v       = (w_op_a[31] != w_val2[31]) && (w_sum[31] != w_op_a[31]);
      end
      CMD_AND: w_alu_res = w_op_a & w_val2;
      CMD_ORR: w_alu_res = w_op_a | w_val2;
      CMD_EOR: w_alu_res = w_op_a ^ w_val2;
      default: ;
    endcase
  end

  assign w_flags = {w_alu_res[31], (w_alu_res == 32'b0), w_c, w_v};

  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{6{signed_imm_in[23]}}, signed_imm_in, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status     <= '0;
      r_alu_result <= '0;
      r_store_val  <= '0;
      r_dst        <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_wb_en      <= 1'b0;
    end else if (!freeze) begin
      if (s_in)
        r_status <= w_flags;
      r_alu_result <= w_alu_res;
      r_store_val  <= w_op_rm;
      r_dst        <= dst_in;
      r_mem_read   <= mem_read_in;
      r_mem_write  <= mem_write_in;
      r_wb_en      <= wb_en_in;
    end
  end

  assign status_out     = r_status;
  assign alu_result_out = r_alu_result;
  assign store_val_out  = r_store_val;
  assign dst_out        = r_dst;
  assign mem_read_out   = r_mem_read;
  assign mem_write_out  = r_mem_write;
  assign wb_en_out      = r_wb_en;

endmodule
